// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Adds two wide operands one nibble per clock, LSB nibble first. It uses a
// single external 4-bit full adder instead of a wide adder. The carry between
// nibbles is chained through an internal register. One operation runs at a
// time, with a start/busy/done handshake.
//
// Ports:
//   clk      system clock; all state updates on the rising edge
//   rst      synchronous active-high reset; has priority over everything
//   start    request, accepted only while idle
//   op_a     operand A (4*NIBBLES bits), sampled on the accepted start
//   op_b     operand B (4*NIBBLES bits), sampled on the accepted start
//   c_in     initial carry, sampled on the accepted start
//   busy     high from the cycle after acceptance until done falls
//   done     one-cycle pulse; result and c_out are valid
//   result   sum, held until the next done
//   c_out    final carry, held until the next done
//   fa_a     nibble of A driven to the external adder
//   fa_b     nibble of B driven to the external adder
//   fa_cin   carry driven to the external adder
//   fa_sum   external adder sum (combinational response)
//   fa_cout  external adder carry-out (combinational response)

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 c_out,
    output logic [3:0]           fa_a,
    output logic [3:0]           fa_b,
    output logic                 fa_cin,
    input  logic [3:0]           fa_sum,
    input  logic                 fa_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     a_q, b_q, work_q, work_d, result_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q, c_out_q;
    logic             last_nibble;
    logic [3:0]       a_nib, b_nib;

    assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));

    // State register: reset returns to IDLE and aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE always lasts exactly one cycle.
    // A start seen in RUN or DONE is dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_nibble) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Select the current nibble of each operand by index. A loop mux is used
    // instead of a variable part-select, so no index can reach past the
    // operand for any NIBBLES value. work_d is the working sum with the
    // adder's current nibble merged in. On the last nibble it is the complete
    // result.
    always_comb begin
        a_nib  = 4'h0;
        b_nib  = 4'h0;
        work_d = work_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib            = a_q[4*i +: 4];
                b_nib            = b_q[4*i +: 4];
                work_d[4*i +: 4] = fa_sum;
            end
        end
    end

    // Datapath registers. Operands are captured only on an accepted start, so
    // changes on op_a/op_b/c_in during RUN have no effect. result and c_out
    // move only on the edge that enters DONE, or on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= c_in;
                        work_q  <= '0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    work_q  <= work_d;
                    carry_q <= fa_cout;
                    if (last_nibble) begin
                        idx_q    <= '0;
                        result_q <= work_d;
                        c_out_q  <= fa_cout;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode. The adder inputs are driven only in RUN. They depend only
    // on registered state, so there is no combinational path from
    // fa_sum/fa_cout back to them.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        fa_a   = 4'h0;
        fa_b   = 4'h0;
        fa_cin = 1'b0;
        if (state_q == RUN) begin
            fa_a   = a_nib;
            fa_b   = b_nib;
            fa_cin = carry_q;
        end
    end

    assign result = result_q;
    assign c_out  = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
//
// Drives a 4-nibble and a 1-nibble controller. Each is attached to a
// behavioural 4-bit adder, and the results are checked against
// hand-computed values and an a+b+c_in reference.

module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst;

    // 4-nibble instance
    logic        start4, c_in4, busy4, done4, c_out4, fa_cin4, fa_cout4;
    logic [15:0] op_a4, op_b4, result4;
    logic [3:0]  fa_a4, fa_b4, fa_sum4;

    // 1-nibble instance
    logic        start1, c_in1, busy1, done1, c_out1, fa_cin1, fa_cout1;
    logic [3:0]  op_a1, op_b1, result1;
    logic [3:0]  fa_a1, fa_b1, fa_sum1;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_a(op_a4), .op_b(op_b4),
        .c_in(c_in4), .busy(busy4), .done(done4), .result(result4),
        .c_out(c_out4), .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4),
        .fa_sum(fa_sum4), .fa_cout(fa_cout4)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
        .c_in(c_in1), .busy(busy1), .done(done1), .result(result1),
        .c_out(c_out1), .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
        .fa_sum(fa_sum1), .fa_cout(fa_cout1)
    );

    // Behavioural external 4-bit full adders
    assign {fa_cout4, fa_sum4} = {1'b0, fa_a4} + {1'b0, fa_b4} + {4'b0, fa_cin4};
    assign {fa_cout1, fa_sum1} = {1'b0, fa_a1} + {1'b0, fa_b1} + {4'b0, fa_cin1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Run one operation on the 4-nibble instance. The start pulse lasts one
    // edge. The nibble stream, the carry chain, busy/done timing and
    // result holding are all checked against the expected values.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic [15:0] exp_res,
                                 input logic exp_c);
        logic [15:0] prev_res;
        logic        prev_c;
        logic        carry;
        logic [4:0]  nsum;
        prev_res = result4;
        prev_c   = c_out4;
        op_a4  = a;
        op_b4  = b;
        c_in4  = cin;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        op_a4  = ~a;
        op_b4  = ~b;
        carry  = cin;
        for (int k = 0; k < 4; k++) begin
            checkOutput("run_busy", 32'(busy4), 32'd1);
            checkOutput("run_done", 32'(done4), 32'd0);
            checkOutput("fa_a", 32'(fa_a4), 32'(a[4*k +: 4]));
            checkOutput("fa_b", 32'(fa_b4), 32'(b[4*k +: 4]));
            checkOutput("fa_cin", 32'(fa_cin4), 32'(carry));
            checkOutput("hold_result", 32'(result4), 32'(prev_res));
            checkOutput("hold_c_out", 32'(c_out4), 32'(prev_c));
            nsum  = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'b0, carry};
            carry = nsum[4];
            tick();
        end
        checkOutput("done_pulse", 32'(done4), 32'd1);
        checkOutput("done_busy", 32'(busy4), 32'd1);
        checkOutput("fa_a_done", 32'(fa_a4), 32'd0);
        checkOutput("result", 32'(result4), 32'(exp_res));
        checkOutput("c_out", 32'(c_out4), 32'(exp_c));
        tick();
        checkOutput("idle_done", 32'(done4), 32'd0);
        checkOutput("idle_busy", 32'(busy4), 32'd0);
        checkOutput("idle_result", 32'(result4), 32'(exp_res));
    endtask

    initial begin
        logic [16:0] ref_sum;
        logic [15:0] ra, rb;
        logic        rc;

        rst = 1'b1;
        start4 = 1'b0; op_a4 = '0; op_b4 = '0; c_in4 = 1'b0;
        start1 = 1'b0; op_a1 = '0; op_b1 = '0; c_in1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(busy4), 32'd0);
        checkOutput("rst_done", 32'(done4), 32'd0);
        checkOutput("rst_result", 32'(result4), 32'd0);
        checkOutput("rst_c_out", 32'(c_out4), 32'd0);
        checkOutput("rst_fa_a", 32'(fa_a4), 32'd0);
        checkOutput("rst_busy1", 32'(busy1), 32'd0);

        $display("[TB] directed ops");
        applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        applyStimulus(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0);

        // Start is held high and the operands change mid-run
        $display("[TB] start held high");
        op_a4 = 16'h0001; op_b4 = 16'h0001; c_in4 = 1'b0; start4 = 1'b1;
        tick();
        op_a4 = 16'h00FF; op_b4 = 16'h00FF;
        for (int k = 0; k < 4; k++) begin
            checkOutput("held_run_done", 32'(done4), 32'd0);
            tick();
        end
        checkOutput("held_done1", 32'(done4), 32'd1);
        checkOutput("held_result1", 32'(result4), 32'h0002);
        tick();
        checkOutput("held_idle_busy", 32'(busy4), 32'd0);
        checkOutput("held_idle_done", 32'(done4), 32'd0);
        tick();
        checkOutput("held_accept_busy", 32'(busy4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("held_run2_done", 32'(done4), 32'd0);
            tick();
        end
        checkOutput("held_done2", 32'(done4), 32'd1);
        checkOutput("held_result2", 32'(result4), 32'h01FE);
        checkOutput("held_c_out2", 32'(c_out4), 32'd0);
        start4 = 1'b0;
        tick();
        checkOutput("held_after_done", 32'(done4), 32'd0);

        // Reset asserted while the run is at idx=2
        $display("[TB] reset mid-run");
        op_a4 = 16'h1111; op_b4 = 16'h2222; c_in4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        checkOutput("pre_rst_fa_a", 32'(fa_a4), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy4), 32'd0);
        checkOutput("abort_done", 32'(done4), 32'd0);
        checkOutput("abort_result", 32'(result4), 32'd0);
        checkOutput("abort_c_out", 32'(c_out4), 32'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("abort_no_done", 32'(done4), 32'd0);
            tick();
        end
        applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // Single-nibble instance: done two cycles after acceptance
        $display("[TB] NIBBLES=1");
        op_a1 = 4'h9; op_b1 = 4'h8; c_in1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checkOutput("n1_busy", 32'(busy1), 32'd1);
        checkOutput("n1_run_done", 32'(done1), 32'd0);
        checkOutput("n1_fa_a", 32'(fa_a1), 32'h9);
        checkOutput("n1_fa_cin", 32'(fa_cin1), 32'd1);
        tick();
        checkOutput("n1_done", 32'(done1), 32'd1);
        checkOutput("n1_result", 32'(result1), 32'h2);
        checkOutput("n1_c_out", 32'(c_out1), 32'd1);
        tick();
        checkOutput("n1_idle", 32'(busy1), 32'd0);

        // Random operations checked against a+b+c_in
        $display("[TB] random ops");
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(1, 0));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            applyStimulus(ra, rb, rc, ref_sum[15:0], ref_sum[16]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
